asteroid_spawner: RTL and testbench
===================================

ASTEROID_SPAWNER -- requirements
Module: asteroid_spawner

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 640, meaning horizontal playfield size in pixels.
REQ-002 The block SHALL have parameter SCREEN_H, default 480, meaning vertical playfield size in pixels.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered random words (power of two, 2..16).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rnd_valid  input  1  one-cycle strobe: rnd_data holds a fresh random word.
REQ-007 rnd_data  input  16  random word from the random generator.
REQ-008 rng_enable  output  1  registered; requests the random generator to run.
REQ-009 spawn_req  input  1  one-cycle request from game logic for one asteroid.
REQ-010 spawn_ready  input  1  object table accepts the presented spawn this cycle.
REQ-011 spawn_valid  output  1  spawn fields valid; held until accepted.
REQ-012 spawn_x  output  10  spawn x coordinate, 0..SCREEN_W-1.
REQ-013 spawn_y  output  9  spawn y coordinate, 0..SCREEN_H-1.
REQ-014 spawn_edge  output  2  entry edge: 0 top, 1 right, 2 bottom, 3 left.
REQ-015 spawn_speed  output  3  inward speed, 1..4.
REQ-016 drop_flag  output  1  sticky: a random word arrived while the FIFO was full.

Function
REQ-017 FIFO: rnd_valid with count<FIFO_DEPTH SHALL push rnd_data; a simultaneous pop SHALL be permitted, with count unchanged.
REQ-018 rnd_valid with count==FIFO_DEPTH and no pop that cycle SHALL discard the word and set drop_flag; drop_flag SHALL clear only on reset.
REQ-019 rng_enable SHALL be registered as (next count < FIFO_DEPTH).
REQ-020 Pending: a 2-bit saturating counter SHALL increment on spawn_req and decrement on dequeue; when both occur in the same cycle it SHALL be unchanged; at 3, a further spawn_req SHALL be ignored.
REQ-021 FSM states IDLE and PRESENT; reset state IDLE.
REQ-022 IDLE: if pending>0 and count>0, the block SHALL pop the head word, decrement pending, load the output fields and enter PRESENT; spawn_valid SHALL be high on the next cycle (1-cycle latency).
REQ-023 PRESENT: spawn_valid=1 and all spawn fields SHALL be held stable until a cycle with spawn_ready=1.
REQ-024 On that cycle the block SHALL go to IDLE with spawn_valid=0 next cycle; there is no back-to-back presentation, and the minimum spacing is 2 cycles.
REQ-025 Mapping from word w: edge=w[15:14]; speed=w[13:12]+1.
REQ-026 Top/bottom edge: spawn_x = w[9:0] if w[9:0]<SCREEN_W, else w[9:0]-SCREEN_W; spawn_y = 0 (top) or SCREEN_H-1 (bottom).
REQ-027 Left/right edge: spawn_y = w[8:0] if w[8:0]<SCREEN_H, else w[8:0]-SCREEN_H; spawn_x = 0 (left) or SCREEN_W-1 (right).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; empty is count==0 and full is count==FIFO_DEPTH.
REQ-029 A pop SHALL never occur on an empty FIFO; while empty, pending requests SHALL wait indefinitely.

Reset
REQ-030 Reset SHALL asynchronously force: rng_enable=0, spawn_valid=0, spawn_x=0, spawn_y=0, spawn_edge=0, spawn_speed=0, drop_flag=0, count=0, pointers=0, pending=0, state IDLE.
REQ-031 Reset asserted during PRESENT SHALL drop spawn_valid immediately; the presented spawn SHALL be lost.
REQ-032 rng_enable SHALL rise on the first clock edge after reset deasserts.

Verification
REQ-033 Push 16'h0123 (edge 0, speed 1) then one spawn_req, with spawn_ready=1 -> one-cycle spawn_valid with x=291, y=0, edge=0, speed=1.
REQ-034 Word 16'h43FF with spawn_req -> edge=1, x=639, y=31 (511-480), speed=1; with spawn_ready held 0 for 5 cycles, spawn_valid and all fields are held stable until the ready cycle.
REQ-035 Word 16'hB2A0 -> edge=2, x=32 (672-640), y=479, speed=4.
REQ-036 Push 4 words without requests -> rng_enable=0 and count=4; a 5th rnd_valid -> drop_flag=1 and the FIFO contents are unchanged; spawn_req in the same cycle as a 5th rnd_valid -> the word is accepted.
REQ-037 Four spawn_req pulses with the FIFO empty -> pending saturates at 3; after 4 words are pushed -> exactly 3 spawns, then 1 word remains.
REQ-038 Reset asserted mid-PRESENT -> spawn_valid=0 asynchronously, count=0, pending=0, and rng_enable=1 one edge after release.

Source files
------------

// File: rtl/asteroid_spawner.sv
// Asteroid spawner: buffers random words in a small FIFO and turns one word
// into one asteroid spawn (edge, position, speed) per pending request.
module asteroid_spawner #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rnd_valid,
   input  logic [15:0]                        rnd_data,
   output logic                               rng_enable,
   input  logic                               spawn_req,
   input  logic                               spawn_ready,
   output logic                               spawn_valid,
   output logic [9:0]                         spawn_x,
   output logic [8:0]                         spawn_y,
   output logic [1:0]                         spawn_edge,
   output logic [2:0]                         spawn_speed,
   output logic                               drop_flag,
   output logic                               dbg_state,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    dbg_count,
   output logic [1:0]                         dbg_pending
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [9:0] W_C   = 10'(SCREEN_W);
   localparam logic [9:0] W_MAX = 10'(SCREEN_W - 1);
   localparam logic [8:0] H_C   = 9'(SCREEN_H);
   localparam logic [8:0] H_MAX = 9'(SCREEN_H - 1);

   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   logic [15:0]      fifo_mem [FIFO_DEPTH];
   state_t           state_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [1:0]       pending_q, pending_d;
   logic             rng_en_q, valid_q, drop_q;
   logic [9:0]       x_q, x_d, x_red;
   logic [8:0]       y_q, y_d, y_red;
   logic [1:0]       edge_q;
   logic [2:0]       speed_q, speed_d;
   logic [15:0]      head_w;
   logic             full, empty, pop, push, drop;
   logic             unused_bits;

   assign head_w      = fifo_mem[rd_ptr_q];
   assign unused_bits = ^head_w[11:10];

   always_comb begin
      full  = (count_q == DEPTH_C);
      empty = (count_q == '0);
      // A request arriving this very cycle already counts, so a full FIFO can
      // take a new word in the same cycle the game asks for a spawn.
      pop   = (state_q == IDLE) && !empty && ((pending_q != 2'd0) || spawn_req);
      push  = rnd_valid && (!full || pop);
      drop  = rnd_valid && full && !pop;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      pending_d = pending_q;
      if (spawn_req && !pop && (pending_q != 2'd3)) pending_d = pending_q + 2'd1;
      else if (pop && !spawn_req)                   pending_d = pending_q - 2'd1;

      x_red   = (head_w[9:0] < W_C) ? head_w[9:0] : head_w[9:0] - W_C;
      y_red   = (head_w[8:0] < H_C) ? head_w[8:0] : head_w[8:0] - H_C;
      speed_d = {1'b0, head_w[13:12]} + 3'd1;
      x_d     = x_red;
      y_d     = y_red;
      case (head_w[15:14])
         2'd0:    begin x_d = x_red; y_d = '0;    end
         2'd1:    begin x_d = W_MAX; y_d = y_red; end
         2'd2:    begin x_d = x_red; y_d = H_MAX; end
         default: begin x_d = '0;    y_d = y_red; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= rnd_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         pending_q <= '0;
         rng_en_q  <= 1'b0;
         drop_q    <= 1'b0;
         valid_q   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         edge_q    <= '0;
         speed_q   <= '0;
      end else begin
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         pending_q <= pending_d;
         rng_en_q  <= (count_d < DEPTH_C);
         drop_q    <= drop_q | drop;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q <= PRESENT;
                  valid_q <= 1'b1;
                  x_q     <= x_d;
                  y_q     <= y_d;
                  edge_q  <= head_w[15:14];
                  speed_q <= speed_d;
               end
            end
            default: begin
               if (spawn_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign rng_enable  = rng_en_q;
   assign spawn_valid = valid_q;
   assign spawn_x     = x_q;
   assign spawn_y     = y_q;
   assign spawn_edge  = edge_q;
   assign spawn_speed = speed_q;
   assign drop_flag   = drop_q;
   assign dbg_state   = state_q;
   assign dbg_count   = count_q;
   assign dbg_pending = pending_q;

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed bench for asteroid_spawner: expected spawns queued on stimulus,
// popped and compared by a negedge monitor on every accepted presentation.
module tb_asteroid_spawner;

   logic        clk = 1'b0;
   logic        reset, rnd_valid, spawn_req, spawn_ready;
   logic [15:0] rnd_data;
   logic        rng_enable, spawn_valid, drop_flag, dbg_state;
   logic [9:0]  spawn_x;
   logic [8:0]  spawn_y;
   logic [1:0]  spawn_edge, dbg_pending;
   logic [2:0]  spawn_speed, dbg_count;

   int total = 0;
   int bad   = 0;
   logic [23:0] exp_q[$];

   always #5 clk = ~clk;

   asteroid_spawner dut (
      .clk(clk), .reset(reset), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
      .rng_enable(rng_enable), .spawn_req(spawn_req), .spawn_ready(spawn_ready),
      .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .spawn_edge(spawn_edge), .spawn_speed(spawn_speed), .drop_flag(drop_flag),
      .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_pending(dbg_pending)
   );

   function automatic logic [23:0] pack(input logic [9:0] x, input logic [8:0] y,
                                        input logic [1:0] e, input logic [2:0] s);
      return {x, y, e, s};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_spawn(input logic [9:0] x, input logic [8:0] y,
                               input logic [1:0] e, input logic [2:0] s);
      exp_q.push_back(pack(x, y, e, s));
   endtask

   task automatic push_word(input logic [15:0] w);
      rnd_valid = 1'b1;
      rnd_data  = w;
      tick();
      rnd_valid = 1'b0;
   endtask

   task automatic req();
      spawn_req = 1'b1;
      tick();
      spawn_req = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !spawn_valid) begin
            done = 1;
            break;
         end
         tick();
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   // Monitor: compare accepted spawns, field stability while stalled, gap after accept.
   logic [23:0] snap;
   logic        stall_prev = 1'b0;
   logic        acc_prev   = 1'b0;
   always @(negedge clk) begin
      logic [23:0] cur;
      logic [23:0] e;
      cur = pack(spawn_x, spawn_y, spawn_edge, spawn_speed);
      if (reset) begin
         stall_prev = 1'b0;
         acc_prev   = 1'b0;
      end else begin
         if (acc_prev) check("gap_after_accept", spawn_valid, 0);
         if (stall_prev) begin
            check("held_valid", spawn_valid, 1);
            check("held_fields", cur, snap);
         end
         if (spawn_valid && spawn_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_spawn: got %0h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("spawn_fields", cur, e);
            end
         end
         stall_prev = spawn_valid && !spawn_ready;
         acc_prev   = spawn_valid && spawn_ready;
         snap       = cur;
      end
   end

   initial begin
      rnd_valid   = 1'b0;
      rnd_data    = '0;
      spawn_req   = 1'b0;
      spawn_ready = 1'b1;
      reset       = 1'b0;
      #1 reset = 1'b1;
      #2;
      check("rst_rng_enable", rng_enable, 0);
      check("rst_valid", spawn_valid, 0);
      check("rst_fields", pack(spawn_x, spawn_y, spawn_edge, spawn_speed), 0);
      check("rst_drop", drop_flag, 0);
      check("rst_count", dbg_count, 0);
      check("rst_pending", dbg_pending, 0);
      check("rst_state", dbg_state, 0);
      tick();
      tick();
      reset = 1'b0;
      check("rng_before_edge", rng_enable, 0);
      tick();
      check("rng_after_release", rng_enable, 1);

      // Basic top-edge spawn with ready held high.
      push_word(16'h0123);
      expect_spawn(10'd291, 9'd0, 2'd0, 3'd1);
      req();
      drain();

      // Right edge, stalled for five cycles.
      spawn_ready = 1'b0;
      push_word(16'h43FF);
      expect_spawn(10'd639, 9'd31, 2'd1, 3'd1);
      req();
      repeat (5) tick();
      check("stall_valid", spawn_valid, 1);
      spawn_ready = 1'b1;
      drain();

      // Bottom edge, left-edge y==SCREEN_H wrap, x boundaries 639 and 640.
      push_word(16'hB2A0);
      expect_spawn(10'd32, 9'd479, 2'd2, 3'd4);
      req();
      drain();
      push_word(16'hD1E0);
      expect_spawn(10'd0, 9'd0, 2'd3, 3'd2);
      req();
      drain();
      push_word(16'h027F);
      expect_spawn(10'd639, 9'd0, 2'd0, 3'd1);
      req();
      drain();
      push_word(16'h3280);
      expect_spawn(10'd0, 9'd0, 2'd0, 3'd4);
      req();
      drain();

      // Fill, overflow drop, then accept a word alongside a pop.
      push_word(16'h0001);
      push_word(16'h4002);
      push_word(16'h8003);
      push_word(16'hC004);
      check("full_count", dbg_count, 4);
      check("full_rng_off", rng_enable, 0);
      check("full_no_drop", drop_flag, 0);
      push_word(16'h0005);
      check("drop_set", drop_flag, 1);
      check("drop_count", dbg_count, 4);
      expect_spawn(10'd1, 9'd0, 2'd0, 3'd1);
      rnd_valid = 1'b1;
      rnd_data  = 16'h4006;
      spawn_req = 1'b1;
      tick();
      rnd_valid = 1'b0;
      spawn_req = 1'b0;
      check("pushpop_count", dbg_count, 4);
      check("pushpop_pending", dbg_pending, 0);
      check("drop_sticky", drop_flag, 1);
      drain();
      expect_spawn(10'd639, 9'd2, 2'd1, 3'd1);
      req();
      drain();
      expect_spawn(10'd3, 9'd479, 2'd2, 3'd1);
      req();
      drain();
      expect_spawn(10'd0, 9'd4, 2'd3, 3'd1);
      req();
      drain();
      expect_spawn(10'd639, 9'd6, 2'd1, 3'd1);
      req();
      drain();
      check("emptied_count", dbg_count, 0);
      check("emptied_rng_on", rng_enable, 1);

      // Pending saturation with an empty FIFO.
      repeat (4) req();
      check("pending_sat", dbg_pending, 3);
      repeat (3) tick();
      check("empty_wait_valid", spawn_valid, 0);
      expect_spawn(10'd16, 9'd0, 2'd0, 3'd2);
      expect_spawn(10'd639, 9'd32, 2'd1, 3'd2);
      expect_spawn(10'd48, 9'd479, 2'd2, 3'd2);
      push_word(16'h1010);
      push_word(16'h5020);
      push_word(16'h9030);
      push_word(16'hD040);
      drain();
      repeat (6) tick();
      check("sat_left_count", dbg_count, 1);
      check("sat_left_pending", dbg_pending, 0);
      expect_spawn(10'd0, 9'd64, 2'd3, 3'd2);
      req();
      drain();

      // Reset while presenting: spawn is lost, state cleared.
      spawn_ready = 1'b0;
      push_word(16'h0123);
      push_word(16'h4002);
      req();
      req();
      check("pre_rst_valid", spawn_valid, 1);
      check("pre_rst_count", dbg_count, 1);
      check("pre_rst_pending", dbg_pending, 1);
      #2 reset = 1'b1;
      #1;
      check("midrst_valid", spawn_valid, 0);
      check("midrst_count", dbg_count, 0);
      check("midrst_pending", dbg_pending, 0);
      check("midrst_rng", rng_enable, 0);
      check("midrst_state", dbg_state, 0);
      spawn_ready = 1'b1;
      tick();
      reset = 1'b0;
      check("rel_rng_before", rng_enable, 0);
      tick();
      check("rel_rng_after", rng_enable, 1);
      repeat (5) tick();
      check("post_rst_idle", spawn_valid, 0);
      check("post_rst_drop", drop_flag, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
